// File: rtl/waveform_pkg.sv
// Shared waveform mode encoding for the waveform generator and its bench.
package waveform_pkg;

    typedef enum logic [1:0] {
        MODE_RAMP   = 2'd0,
        MODE_TRI    = 2'd1,
        MODE_SQUARE = 2'd2,
        MODE_SINE   = 2'd3
    } mode_e;

endpackage

// File: rtl/sine_quarter_rom.sv
// Combinational quarter-wave sine magnitude table, filled at elaboration time.
module sine_quarter_rom #(
    parameter int DATA_W = 8,
    parameter int LUT_AW = 6
) (
    input  logic [LUT_AW-1:0] i_addr,
    output logic [DATA_W-1:0] o_mag
);

    localparam int  DEPTH = 2 ** LUT_AW;
    localparam real PI    = 3.14159265358979323846;
    localparam real AMP   = (2.0 ** (DATA_W - 1)) - 1.0;

    logic [DATA_W-1:0] lut_w [DEPTH];

    // Entries are non-negative, so adding 0.5 before truncation rounds to nearest.
    for (genvar k = 0; k < DEPTH; k++) begin : g_lut
        localparam int MAG = $rtoi(AMP * $sin(PI / 2.0 * (k * 1.0) / (DEPTH * 1.0)) + 0.5);
        assign lut_w[k] = DATA_W'(MAG);
    end

    assign o_mag = lut_w[i_addr];

endmodule

// File: rtl/waveform_generator.sv
// Phase-accumulator waveform source producing ramp, triangle, square or sine
// samples with a valid strobe and an end-of-period marker.
module waveform_generator
    import waveform_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PHASE_W = 16,
    parameter int LUT_AW  = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_phase_clr,
    input  logic [1:0]         i_mode,
    input  logic [PHASE_W-1:0] i_step,
    output logic [DATA_W-1:0]  o_sample,
    output logic               o_valid,
    output logic               o_wrap
);

    localparam logic [DATA_W-1:0] MID      = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] FULL     = {DATA_W{1'b1}};

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [DATA_W-1:0]  sample_q, sample_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;

    logic [PHASE_W:0]   sum_w;
    logic               msb_w;
    logic               quad_odd_w;
    logic [DATA_W-1:0]  tri_r_w;
    logic [LUT_AW-1:0]  idx_w;
    logic [DATA_W-1:0]  mag_w;
    logic [DATA_W-1:0]  wave_w;

    assign sum_w      = {1'b0, phase_q} + {1'b0, i_step};
    assign msb_w      = phase_q[PHASE_W-1];
    assign quad_odd_w = phase_q[PHASE_W-2];
    assign tri_r_w    = phase_q[PHASE_W-2 -: DATA_W];
    // Odd quadrants walk the quarter table backwards to mirror the sine slope.
    assign idx_w      = quad_odd_w ? ~phase_q[PHASE_W-3 -: LUT_AW]
                                   :  phase_q[PHASE_W-3 -: LUT_AW];

    sine_quarter_rom #(
        .DATA_W (DATA_W),
        .LUT_AW (LUT_AW)
    ) u_rom (
        .i_addr (idx_w),
        .o_mag  (mag_w)
    );

    always_comb begin
        wave_w = phase_q[PHASE_W-1 -: DATA_W];
        case (mode_e'(i_mode))
            MODE_RAMP:   wave_w = phase_q[PHASE_W-1 -: DATA_W];
            MODE_TRI:    wave_w = msb_w ? ~tri_r_w : tri_r_w;
            MODE_SQUARE: wave_w = msb_w ? '0 : FULL;
            MODE_SINE:   wave_w = msb_w ? (MID - mag_w) : (MID + mag_w);
            default:     wave_w = phase_q[PHASE_W-1 -: DATA_W];
        endcase
    end

    always_comb begin
        phase_d  = phase_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        wrap_d   = 1'b0;
        if (i_phase_clr) begin
            phase_d = '0;
        end else if (i_en) begin
            sample_d = wave_w;
            phase_d  = sum_w[PHASE_W-1:0];
            valid_d  = 1'b1;
            wrap_d   = sum_w[PHASE_W];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase_q  <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            wrap_q   <= wrap_d;
        end
    end

    assign o_sample = sample_q;
    assign o_valid  = valid_q;
    assign o_wrap   = wrap_q;

endmodule

// File: tb/tb_waveform_generator.sv
// Directed bench for waveform_generator with a scoreboard of expected samples.
module tb_waveform_generator;
    import waveform_pkg::*;

    localparam int DATA_W  = 8;
    localparam int PHASE_W = 16;
    localparam int LUT_AW  = 6;

    typedef struct packed {
        logic [DATA_W-1:0] s;
        logic              v;
        logic              w;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic               clr = 1'b0;
    logic [1:0]         mode = 2'd0;
    logic [PHASE_W-1:0] step = '0;
    logic [DATA_W-1:0]  sample;
    logic               valid;
    logic               wrap;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [PHASE_W-1:0] phase_m  = '0;
    logic [DATA_W-1:0]  sample_m = '0;
    exp_t               sb_q[$];

    always #5 clk = ~clk;

    waveform_generator #(
        .DATA_W  (DATA_W),
        .PHASE_W (PHASE_W),
        .LUT_AW  (LUT_AW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_phase_clr (clr),
        .i_mode      (mode),
        .i_step      (step),
        .o_sample    (sample),
        .o_valid     (valid),
        .o_wrap      (wrap)
    );

    function automatic logic [DATA_W-1:0] wave(input logic [1:0] m, input logic [PHASE_W-1:0] p);
        logic [DATA_W-1:0] r;
        int                k;
        int                mag;
        case (m)
            2'd0: return p[15:8];
            2'd1: begin
                r = p[14:7];
                return p[15] ? ~r : r;
            end
            2'd2: return p[15] ? 8'd0 : 8'd255;
            default: begin
                k = int'(p[13:8]);
                if (p[14]) k = 63 - k;
                mag = $rtoi(127.0 * $sin(3.14159265358979 / 2.0 * k / 64.0) + 0.5);
                return p[15] ? 8'(128 - mag) : 8'(128 + mag);
            end
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        tests_run++;
        assert (obs === expv)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic d_en, input logic d_clr);
        exp_t             e;
        logic [PHASE_W:0] sum;
        @(negedge clk);
        en  = d_en;
        clr = d_clr;
        if (d_clr) begin
            phase_m = '0;
            e = '{s: sample_m, v: 1'b0, w: 1'b0};
        end else if (d_en) begin
            sample_m = wave(mode, phase_m);
            sum      = {1'b0, phase_m} + {1'b0, step};
            phase_m  = sum[PHASE_W-1:0];
            e = '{s: sample_m, v: 1'b1, w: sum[PHASE_W]};
        end else begin
            e = '{s: sample_m, v: 1'b0, w: 1'b0};
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            check("sample", int'(sample), int'(e.s));
            check("valid", int'(valid), int'(e.v));
            check("wrap", int'(wrap), int'(e.w));
            if (mode == 2'd3 && valid) check("sine_nonzero", int'(sample != 8'd0), 1);
        end
    endtask

    initial begin
        #12;
        check("reset_sample", int'(sample), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_wrap", int'(wrap), 0);
        @(negedge clk);
        rst_n = 1'b1;

        mode = MODE_RAMP;
        step = 16'h0100;
        for (int i = 0; i < 258; i++) drive(1'b1, 1'b0);

        drive(1'b1, 1'b1);
        mode = MODE_TRI;
        for (int i = 0; i < 257; i++) drive(1'b1, 1'b0);

        drive(1'b0, 1'b1);
        mode = MODE_SQUARE;
        step = 16'h4000;
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0);

        drive(1'b0, 1'b1);
        mode = MODE_SINE;
        step = 16'h0100;
        for (int i = 0; i < 257; i++) drive(1'b1, 1'b0);

        drive(1'b0, 1'b1);
        mode = MODE_RAMP;
        for (int i = 0; i < 11; i++) drive(1'b1, 1'b0);
        check("gap_last_sample", int'(sample), 10);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0);
        check("gap_hold", int'(sample), 10);
        drive(1'b1, 1'b0);
        check("gap_resume", int'(sample), 11);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        check("clear_first", int'(sample), 0);

        mode = MODE_SINE;
        for (int i = 0; i < 40; i++) drive(1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_sample", int'(sample), 0);
        check("async_rst_valid", int'(valid), 0);
        check("async_rst_wrap", int'(wrap), 0);
        phase_m  = '0;
        sample_m = '0;
        step = '0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0);
        check("post_rst_mid", int'(sample), 128);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0);
        check("step0_const", int'(sample), 128);

        @(negedge clk);
        en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/waveform_generator.md
# waveform_generator

Parametrised digital waveform source: a phase accumulator drives selectable ramp, triangle, square or sine output. Frequency is set by a runtime phase step, and each sample is marked with a valid strobe. It replaces the fixed 3-bit ramp source as the stimulus generator ahead of the FIR filter input. Samples are unsigned and offset-binary, with midscale equal to 2^(DATA_W-1).

## Interface
- DATA_W, 8, output sample width; must satisfy DATA_W <= PHASE_W-1
- PHASE_W, 16, phase accumulator width
- LUT_AW, 6, quarter-wave sine table address width (2^LUT_AW entries); must satisfy LUT_AW <= PHASE_W-2
- i_clk  input  1  sole clock, rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_en  input  1  advance phase and emit one sample this cycle
- i_phase_clr  input  1  synchronous phase clear; has priority over i_en
- i_mode  input  2  waveform select: 0 ramp, 1 triangle, 2 square, 3 sine
- i_step  input  PHASE_W  phase increment per enabled cycle
- o_sample  output  DATA_W  registered sample
- o_valid  output  1  o_sample was updated at the last edge
- o_wrap  output  1  current sample is the last of a period

## Operation
- Phase register P, modulo 2^PHASE_W. Define MSB = P[PHASE_W-1] and quadrant q = P[PHASE_W-1:PHASE_W-2].
- Ramp: P[PHASE_W-1 -: DATA_W].
- Triangle: r = P[PHASE_W-2 -: DATA_W]; output = MSB ? ~r : r.
- Square: MSB ? 0 : 2^DATA_W-1. The first half-period is high.
- Sine:
  - idx = P[PHASE_W-3 -: LUT_AW]; use ~idx in quadrants 1 and 3.
  - mag = LUT[idx].
  - Output = mid+mag for q=0 or 1, and mid-mag for q=2 or 3, where mid = 2^(DATA_W-1).
  - LUT[k] = round((2^(DATA_W-1)-1) * sin(pi/2 * k/2^LUT_AW)), computed at elaboration.
  - Output range is 1 to 2^DATA_W-1. The value 0 never occurs in sine mode.
- Enabled cycle (i_en=1, i_phase_clr=0):
  - o_sample <= f(i_mode, P), using the pre-increment phase.
  - P <= P+i_step.
  - o_valid <= 1.
  - o_wrap <= carry-out of P+i_step.
- Idle cycle (i_en=0, i_phase_clr=0): P holds, o_sample holds, o_valid <= 0, o_wrap <= 0.
- Clear (i_phase_clr=1, regardless of i_en): P <= 0, o_sample holds, o_valid <= 0, o_wrap <= 0.
- i_mode and i_step are sampled on every enabled cycle with no shadowing.
  - A change applies from the very next sample, with no phase discontinuity.
  - i_step=0 gives a constant output with o_wrap never asserted.
- i_step is used as-is. Values of 2^(PHASE_W-1) or more alias; this is legal but not band-limited.

## Timing
- Latency: 1 cycle from an enabled edge to a new o_sample, with o_valid and o_wrap aligned to it.
- Throughput: one sample per clock while i_en=1.
- First sample after reset or clear is f(mode, 0):
  - ramp 0
  - triangle 0
  - square 2^DATA_W-1
  - sine mid
- Reset values: P=0, o_sample=0, o_valid=0, o_wrap=0.
- Reset asserted mid-operation clears outputs immediately (asynchronous). Release is synchronised externally.
- o_wrap is high for exactly one cycle, alongside the final pre-wrap sample. It is never high while o_valid=0.

## Structure
- Package waveform_pkg holds the mode constants MODE_RAMP, MODE_TRI, MODE_SQUARE and MODE_SINE, plus the 2-bit mode type.
- Sub-module sine_quarter_rom holds the combinational quarter-wave LUT, parameterised by DATA_W and LUT_AW.
- The top level contains the accumulator, the mode mux and the output registers.

## Test plan
All scenarios use DATA_W=8, PHASE_W=16, LUT_AW=6.
- Ramp, step 0x0100, i_en held high after reset release: o_sample = 0,1,…,255,0,… and o_wrap is high only with 255.
- Triangle, step 0x0100: o_sample = 0,2,…,254,255,253,…,1, then repeats; o_wrap is high with 1.
- Square, step 0x4000: o_sample = 255,255,0,0 repeating; o_wrap is high on the 4th sample.
- Sine, step 0x0100: samples 0/64/128/192 of each period = 128/255/128/1; the output is never 0 and never exceeds 255.
- Ramp with an i_en gap and a clear:
  - Drop i_en for 3 cycles after sample 10: o_valid is low, o_sample holds at 10, then resumes at 11.
  - i_phase_clr together with i_en=1: no valid sample that cycle; the next valid sample is 0.
- Assert i_rst_n low mid-period: o_sample, o_valid and o_wrap are 0 immediately. After release, the first sample is f(mode, 0). With i_step=0 the output stays constant and o_wrap stays 0.
